lcd_mmio_controller: RTL and testbench
======================================

Name: lcd_mmio_controller

Overview:
- Memory-mapped LCD interface that sits between the CPU's I/O-space store path and the HD44780-style LCD pins. It replaces software bit-banging of the data, ctrl and enable registers.
- The CPU writes characters or commands into a small FIFO.
- A timing FSM drains the FIFO and drives lcd_data, lcd_ctrl and lcd_enable with guaranteed setup, pulse, hold and execution delays.
- A status register lets firmware poll busy, full and overflow.

Parameters:
- DEPTH, 8: FIFO entries; power of two, at least 2.
- SETUP_CYCLES, 2: cycles that data and ctrl are stable before enable rises; at least 1.
- PULSE_CYCLES, 4: cycles that enable is high; at least 1.
- HOLD_CYCLES, 2: cycles that data and ctrl are held after enable falls; at least 1.
- EXEC_CYCLES, 50: post-transfer wait for normal commands and data.
- LONG_EXEC_CYCLES, 2000: post-transfer wait for clear (0x01) and home (0x02, 0x03) commands.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  store strobe, already qualified by the I/O-space decode.
- wr_addr  in  2  register select.
- wr_data  in  32  store data; bits [7:0] are used.
- rd_addr  in  2  register select for reads.
- rd_data  out  32  combinational read data.
- lcd_data  out  8  LCD data bus.
- lcd_ctrl  out  2  {RS, RW}. RS=1 means data, RS=0 means command. RW is always 0.
- lcd_enable  out  1  LCD E strobe.

Behaviour:
- Register map, writes (wr_en=1):
  - addr 0: push {RS=1, wr_data[7:0]}.
  - addr 1: push {RS=0, wr_data[7:0]}.
  - addr 2: no effect.
  - addr 3: clear the overflow flag.
- Register map, reads:
  - addr 2: bit0 busy, bit1 full, bit2 empty, bit3 overflow, bits[7:4] FIFO count (saturates at 15), other bits 0.
  - Any other read address returns 0.
- busy = (state != IDLE) | !empty.
- FIFO:
  - DEPTH x 9 bits, circular read and write pointers plus a count.
  - A push while full is dropped and sets overflow (sticky until an addr-3 write or rst).
  - The FSM pops only in IDLE. Pop and push in the same cycle are both honoured; count is unchanged.
  - A push while full is dropped even if a pop happens that cycle. The full check uses the registered count.
- FSM states: IDLE, SETUP, PULSE, HOLD, WAIT. A single down-counter, sized for LONG_EXEC_CYCLES, is used.
- IDLE:
  - If not empty: pop; register lcd_data and lcd_ctrl from the entry; load SETUP_CYCLES-1; go to SETUP.
  - Otherwise remain in IDLE.
- SETUP:
  - enable=0.
  - When the counter reaches 0: load PULSE_CYCLES-1, set lcd_enable=1, go to PULSE.
- PULSE:
  - enable=1.
  - When the counter reaches 0: set lcd_enable=0, load HOLD_CYCLES-1, go to HOLD.
- HOLD:
  - enable=0, data held.
  - When the counter reaches 0: load EXEC-1, go to WAIT.
  - EXEC is LONG_EXEC_CYCLES when RS=0 and data[7:2]==0 and data[1:0]!=0; otherwise it is EXEC_CYCLES.
- WAIT: when the counter reaches 0, go to IDLE. lcd_data and lcd_ctrl keep their last values.
- Timing:
  - A write accepted at edge N becomes visible on the pins at edge N+1, when lcd_data and lcd_ctrl update.
  - lcd_enable rises at edge N+1+SETUP_CYCLES and stays high exactly PULSE_CYCLES cycles.
  - Successive transfers have rising edges of enable spaced 1+SETUP+PULSE+HOLD+EXEC cycles apart (59 with the defaults).
- All outputs are registered except rd_data. lcd_enable is glitch-free.
- Reset (synchronous, active-high, takes effect mid-transfer too):
  - state=IDLE, FIFO emptied, overflow=0, lcd_data=0, lcd_ctrl=0, lcd_enable=0, counter=0.
  - An in-progress pulse is truncated (enable goes to 0 at the reset edge).
  - A wr_en asserted in the same cycle as rst is ignored.

Test Plan:
- Reset, then write 0x41 to addr 0 at edge N → lcd_data=0x41 and lcd_ctrl=2'b10 from N+1; enable high for edges N+3..N+7 (4 cycles); status busy=1 until N+59, then 0x04 (empty).
- Write command 0x01 to addr 1, then data 0x42 → second enable rise is 1+2+4+2+2000=2009 cycles after the first; ctrl=2'b00 then 2'b10. Repeat with 0x38 → spacing 59.
- Write 9 bytes back-to-back while the FSM is busy (DEPTH=8) → 8 accepted in order; status full=1, overflow=1, count=8. Write to addr 3 → overflow=0. Drained output order matches the write order.
- FIFO full, and a write lands in the cycle the FSM pops → the write is dropped and overflow is set; count goes to 7.
- Assert rst while in PULSE → enable=0 at the next edge, status reads 0x04, and no further pulses occur.
- Read addr 0, 1 and 3 → 0. Write to addr 2 → no push; count unchanged.

Source files
------------

// File: rtl/lcd_mmio_controller_if.sv
// CPU-side store/read bus for the memory-mapped LCD controller.
//   wr_en    store strobe, already qualified by the I/O-space decode
//   wr_addr  register select for stores
//   wr_data  store data, bits [7:0] carry the character or command
//   rd_addr  register select for loads
//   rd_data  combinational load data returned by the controller
interface lcd_mmio_controller_if;
   logic        wr_en;
   logic [1:0]  wr_addr;
   logic [31:0] wr_data;
   logic [1:0]  rd_addr;
   logic [31:0] rd_data;

   modport master (
      output wr_en,
      output wr_addr,
      output wr_data,
      output rd_addr,
      input  rd_data
   );

   modport slave (
      input  wr_en,
      input  wr_addr,
      input  wr_data,
      input  rd_addr,
      output rd_data
   );
endinterface

// File: rtl/lcd_mmio_controller.sv
// Memory-mapped HD44780-style LCD controller: CPU stores are queued in a FIFO
// and a timing FSM drives each entry onto the LCD pins with setup, enable
// pulse, hold and execution delays.
//   clk         system clock
//   rst         synchronous active-high reset
//   bus         CPU store/read bus (slave side)
//   lcd_data    LCD data bus (registered)
//   lcd_ctrl    {RS, RW}; RS=1 data, RS=0 command, RW always 0 (registered)
//   lcd_enable  LCD E strobe (registered, glitch-free)
module lcd_mmio_controller #(
   parameter int unsigned DEPTH            = 8,
   parameter int unsigned SETUP_CYCLES     = 2,
   parameter int unsigned PULSE_CYCLES     = 4,
   parameter int unsigned HOLD_CYCLES      = 2,
   parameter int unsigned EXEC_CYCLES      = 50,
   parameter int unsigned LONG_EXEC_CYCLES = 2000
) (
   input  logic                  clk,
   input  logic                  rst,
   lcd_mmio_controller_if.slave  bus,
   output logic [7:0]            lcd_data,
   output logic [1:0]            lcd_ctrl,
   output logic                  lcd_enable
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   // The one down-counter must hold the largest load value of any phase.
   localparam int unsigned MAX_A   = (LONG_EXEC_CYCLES > EXEC_CYCLES) ? LONG_EXEC_CYCLES : EXEC_CYCLES;
   localparam int unsigned MAX_B   = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
   localparam int unsigned MAX_C   = (MAX_B > HOLD_CYCLES) ? MAX_B : HOLD_CYCLES;
   localparam int unsigned TMR_MAX = (MAX_A > MAX_C) ? MAX_A : MAX_C;
   localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD,
      ST_WAIT
   } state_t;

   // FIFO storage and bookkeeping; entry is {RS, byte}.
   logic [8:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             ovf_q;

   logic             wr_hit;
   logic             push_req;
   logic             push;
   logic             pop;
   logic             clr_ovf;
   logic             full;
   logic             empty;
   logic [8:0]       head;

   // Timing FSM state.
   state_t           state_q;
   state_t           state_d;
   logic [TMR_W-1:0] tmr_q;
   logic [TMR_W-1:0] tmr_d;
   logic [7:0]       data_d;
   logic [1:0]       ctrl_d;
   logic             en_d;
   logic             tmr_zero;
   logic [TMR_W-1:0] tmr_dec;
   logic             long_cmd;

   logic [3:0]       cnt_sat;
   logic             busy;

   // Upper store bits carry nothing for this peripheral.
   logic             unused_wr_hi;
   assign unused_wr_hi = ^bus.wr_data[31:8];

   // Store decode; stores coinciding with reset are discarded.
   assign wr_hit   = bus.wr_en && !rst;
   assign push_req = wr_hit && !bus.wr_addr[1];
   assign clr_ovf  = wr_hit && (bus.wr_addr == 2'd3);

   // Full is judged on the registered count, so a same-cycle pop cannot rescue a push.
   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign push  = push_req && !full;
   assign pop   = (state_q == ST_IDLE) && !empty;
   assign head  = mem[rd_ptr_q];

   // FIFO storage write port.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= {!bus.wr_addr[0], bus.wr_data[7:0]};
      end
   end

   // FIFO pointers, occupancy and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
         if (clr_ovf) begin
            ovf_q <= 1'b0;
         end else if (push_req && full) begin
            ovf_q <= 1'b1;
         end
      end
   end

   assign tmr_zero = (tmr_q == '0);
   assign tmr_dec  = tmr_q - TMR_W'(1);

   // Clear (0x01) and return-home (0x02/0x03) commands need the long execution wait.
   assign long_cmd = !lcd_ctrl[1] && (lcd_data[7:2] == 6'd0) && (lcd_data[1:0] != 2'd0);

   // FSM state and pin registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         tmr_q      <= '0;
         lcd_data   <= 8'd0;
         lcd_ctrl   <= 2'b00;
         lcd_enable <= 1'b0;
      end else begin
         state_q    <= state_d;
         tmr_q      <= tmr_d;
         lcd_data   <= data_d;
         lcd_ctrl   <= ctrl_d;
         lcd_enable <= en_d;
      end
   end

   // Next-state and next-pin logic; enable is only ever high in PULSE.
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      data_d  = lcd_data;
      ctrl_d  = lcd_ctrl;
      en_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!empty) begin
               data_d  = head[7:0];
               ctrl_d  = {head[8], 1'b0};
               tmr_d   = TMR_W'(SETUP_CYCLES - 1);
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (tmr_zero) begin
               tmr_d   = TMR_W'(PULSE_CYCLES - 1);
               en_d    = 1'b1;
               state_d = ST_PULSE;
            end else begin
               tmr_d = tmr_dec;
            end
         end
         ST_PULSE: begin
            if (tmr_zero) begin
               tmr_d   = TMR_W'(HOLD_CYCLES - 1);
               state_d = ST_HOLD;
            end else begin
               en_d  = 1'b1;
               tmr_d = tmr_dec;
            end
         end
         ST_HOLD: begin
            if (tmr_zero) begin
               tmr_d   = long_cmd ? TMR_W'(LONG_EXEC_CYCLES - 1) : TMR_W'(EXEC_CYCLES - 1);
               state_d = ST_WAIT;
            end else begin
               tmr_d = tmr_dec;
            end
         end
         ST_WAIT: begin
            if (tmr_zero) begin
               state_d = ST_IDLE;
            end else begin
               tmr_d = tmr_dec;
            end
         end
         default: begin
            state_d = ST_IDLE;
            tmr_d   = '0;
         end
      endcase
   end

   // Status register read path.
   assign busy    = (state_q != ST_IDLE) || !empty;
   assign cnt_sat = (32'(count_q) > 32'd15) ? 4'hF : 4'(count_q);

   always_comb begin
      bus.rd_data = 32'd0;
      if (bus.rd_addr == 2'd2) begin
         bus.rd_data[7:0] = {cnt_sat, ovf_q, empty, full, busy};
      end
   end

endmodule

// File: tb/tb_lcd_mmio_controller.sv
// Randomized self-checking bench for lcd_mmio_controller against a
// transaction-level model (queue of pending entries plus transfer timeline).
module tb_lcd_mmio_controller;

   localparam int unsigned DEPTH     = 8;
   localparam int unsigned SETUP     = 2;
   localparam int unsigned PULSE     = 4;
   localparam int unsigned HOLD      = 2;
   localparam int unsigned EXEC      = 50;
   localparam int unsigned LONG_EXEC = 2000;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] lcd_data;
   logic [1:0] lcd_ctrl;
   logic       lcd_enable;

   lcd_mmio_controller_if bus ();

   lcd_mmio_controller #(
      .DEPTH            (DEPTH),
      .SETUP_CYCLES     (SETUP),
      .PULSE_CYCLES     (PULSE),
      .HOLD_CYCLES      (HOLD),
      .EXEC_CYCLES      (EXEC),
      .LONG_EXEC_CYCLES (LONG_EXEC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus.slave),
      .lcd_data   (lcd_data),
      .lcd_ctrl   (lcd_ctrl),
      .lcd_enable (lcd_enable)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;
   int edge_n  = 0;   // index of the next rising edge

   // Reference model: pending entries, pin values, enable window, next pop edge.
   logic [8:0] m_q[$];
   bit         m_ovf     = 1'b0;
   int         m_next_pop = 0;
   logic [7:0] m_data    = 8'd0;
   logic [1:0] m_ctrl    = 2'b00;
   int         m_en_lo   = 0;
   int         m_en_hi   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, edge_n - 1, got, exp);
      end
   endtask

   // A transfer occupies one pop cycle plus setup, pulse, hold and execution time.
   function automatic int xfer_len(input logic [8:0] it);
      int ex;
      ex = EXEC;
      if (!it[8] && (it[7:0] inside {8'h01, 8'h02, 8'h03})) begin
         ex = LONG_EXEC;
      end
      return 1 + SETUP + PULSE + HOLD + ex;
   endfunction

   task automatic model_step(input bit r, input bit we, input logic [1:0] wa,
                             input logic [7:0] wd, input int e);
      int         sz;
      logic [8:0] it;
      if (r) begin
         m_q.delete();
         m_ovf      = 1'b0;
         m_next_pop = e + 1;
         m_data     = 8'd0;
         m_ctrl     = 2'b00;
         m_en_lo    = 0;
         m_en_hi    = 0;
         return;
      end
      sz = m_q.size();
      if (sz > 0 && e >= m_next_pop) begin
         it         = m_q.pop_front();
         m_data     = it[7:0];
         m_ctrl     = {it[8], 1'b0};
         m_en_lo    = e + SETUP;
         m_en_hi    = e + SETUP + PULSE;
         m_next_pop = e + xfer_len(it);
      end
      if (we && wa <= 2'd1) begin
         if (sz == DEPTH) m_ovf = 1'b1;
         else             m_q.push_back({(wa == 2'd0), wd});
      end
      if (we && wa == 2'd3) m_ovf = 1'b0;
   endtask

   task automatic check_all(input logic [1:0] ra);
      int         last;
      int         sz;
      logic [3:0] cnt;
      logic       busy;
      logic [31:0] exp_rd;
      logic       exp_en;
      last   = edge_n - 1;
      sz     = m_q.size();
      cnt    = (sz > 15) ? 4'hF : 4'(sz);
      busy   = (sz != 0) || (last < m_next_pop - 1);
      exp_rd = 32'd0;
      if (ra == 2'd2) exp_rd = {24'd0, cnt, m_ovf, (sz == 0), (sz == DEPTH), busy};
      exp_en = (last >= m_en_lo) && (last < m_en_hi);
      check_eq("rd_data", bus.rd_data, exp_rd);
      check_eq("lcd_data", 32'(lcd_data), 32'(m_data));
      check_eq("lcd_ctrl", 32'(lcd_ctrl), 32'(m_ctrl));
      check_eq("lcd_enable", 32'(lcd_enable), 32'(exp_en));
   endtask

   // One clock: check outputs mid-cycle, then drive inputs for the next edge.
   task automatic cycle(input bit r, input bit we, input logic [1:0] wa,
                        input logic [7:0] wd, input logic [1:0] ra);
      @(negedge clk);
      bus.rd_addr = ra;
      #1;
      check_all(ra);
      rst         = r;
      bus.wr_en   = we;
      bus.wr_addr = wa;
      bus.wr_data = {24'($urandom()), wd};
      @(posedge clk);
      model_step(r, we, wa, wd, edge_n);
      edge_n++;
   endtask

   function automatic logic [1:0] pick_ra();
      if ($urandom_range(0, 3) == 0) return 2'($urandom_range(0, 3));
      return 2'd2;
   endfunction

   task automatic idle(input int n);
      repeat (n) cycle(1'b0, 1'b0, 2'd0, 8'd0, pick_ra());
   endtask

   task automatic wr(input logic [1:0] wa, input logic [7:0] wd);
      cycle(1'b0, 1'b1, wa, wd, pick_ra());
   endtask

   int rates[4] = '{8, 40, 60, 100};

   initial begin
      rst         = 1'b1;
      bus.wr_en   = 1'b0;
      bus.wr_addr = 2'd0;
      bus.wr_data = 32'd0;
      bus.rd_addr = 2'd2;
      @(posedge clk);
      @(posedge clk);
      model_step(1'b1, 1'b0, 2'd0, 8'd0, edge_n);
      edge_n++;

      // Single character, then command/data pairs with long and short execution.
      wr(2'd0, 8'h41);
      idle(70);
      wr(2'd1, 8'h01);
      wr(2'd0, 8'h42);
      idle(2100);
      wr(2'd1, 8'h38);
      wr(2'd0, 8'h42);
      idle(130);

      // Nine stores while busy: one overflow, then clear it and drain.
      wr(2'd0, 8'h30);
      idle(2);
      for (int i = 0; i < 9; i++) wr(2'd0, 8'(8'h60 + i));
      idle(3);
      wr(2'd3, 8'h00);
      wr(2'd2, 8'h55);
      idle(9 * 59 + 20);

      // FIFO full and a store lands on the pop edge: it must be dropped.
      wr(2'd0, 8'h31);
      idle(2);
      for (int i = 0; i < 8; i++) wr(2'd0, 8'($urandom()));
      while (edge_n < m_next_pop) idle(1);
      wr(2'd0, 8'hEE);
      idle(2);
      wr(2'd3, 8'h00);
      idle(9 * 59 + 20);

      // Reset in the middle of the enable pulse, with a store in the same cycle.
      wr(2'd0, 8'h5A);
      while (edge_n - 1 < m_en_lo + 1) idle(1);
      cycle(1'b1, 1'b1, 2'd0, 8'h77, 2'd2);
      idle(100);

      // Random traffic at several store rates with occasional resets.
      for (int s = 0; s < 4; s++) begin
         repeat (1500) begin
            cycle(($urandom_range(0, 499) == 0),
                  ($urandom_range(1, rates[s]) == 1),
                  2'($urandom_range(0, 3)),
                  8'($urandom()),
                  pick_ra());
         end
      end
      idle(2200);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
